// File: rtl/sdram_burst_timing.sv
// SDRAM controller timing helper: CAS-latency counter, burst-length counter
// with end / end-minus-one flags, and a 16-tap addressable strobe delay line.
module sdram_burst_timing #(
   parameter int CSLT_W = 2,
   parameter int BRST_W = 3
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [CSLT_W-1:0] cslt_max,
   input  logic              ld_cslt,
   output logic              cslt_end,
   input  logic [BRST_W-1:0] brst_max,
   input  logic              ld_brst,
   output logic              brst_end,
   output logic              brst_end_m1,
   input  logic [3:0]        dly_a,
   input  logic              dly_d,
   output logic              dly_q
);

   localparam logic [CSLT_W-1:0] CSLT_ZERO = CSLT_W'(0);
   localparam logic [CSLT_W-1:0] CSLT_ONE  = CSLT_W'(1);
   localparam logic [BRST_W-1:0] BRST_ZERO = BRST_W'(0);
   localparam logic [BRST_W-1:0] BRST_ONE  = BRST_W'(1);

   logic [CSLT_W-1:0] cslt_cnt_r;
   logic [BRST_W-1:0] brst_cnt_r;
   logic [15:0]       dly_r;

   // CAS-latency counter: load wins, otherwise count down and stick at zero
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cslt_cnt_r <= CSLT_ZERO;
      end else if (ld_cslt) begin
         cslt_cnt_r <= cslt_max;
      end else if (cslt_cnt_r != CSLT_ZERO) begin
         cslt_cnt_r <= cslt_cnt_r - CSLT_ONE;
      end else begin
         cslt_cnt_r <= cslt_cnt_r;
      end
   end

   // Burst-length counter: same load/decrement/hold rules as the CAS counter
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         brst_cnt_r <= BRST_ZERO;
      end else if (ld_brst) begin
         brst_cnt_r <= brst_max;
      end else if (brst_cnt_r != BRST_ZERO) begin
         brst_cnt_r <= brst_cnt_r - BRST_ONE;
      end else begin
         brst_cnt_r <= brst_cnt_r;
      end
   end

   // Strobe delay line: free-running shift, stage 0 takes the newest sample
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         dly_r <= 16'h0000;
      end else begin
         dly_r <= {dly_r[14:0], dly_d};
      end
   end

   // End flags decode the registered counts; tap select is a pure mux so the
   // state machine sees a new delay immediately without disturbing contents
   always_comb begin
      cslt_end    = (cslt_cnt_r == CSLT_ZERO);
      brst_end    = (brst_cnt_r == BRST_ZERO);
      brst_end_m1 = (brst_cnt_r == BRST_ONE);
      dly_q       = dly_r[dly_a];
   end

endmodule

// File: tb/tb_sdram_burst_timing.sv
// Self-checking bench for sdram_burst_timing: directed vector table, hand
// sequences for reload/pattern/async reset, and a randomized model comparison.
module tb_sdram_burst_timing;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [1:0] cslt_max;
   logic       ld_cslt;
   logic       cslt_end;
   logic [2:0] brst_max;
   logic       ld_brst;
   logic       brst_end;
   logic       brst_end_m1;
   logic [3:0] dly_a;
   logic       dly_d;
   logic       dly_q;

   int n_chk  = 0;
   int n_pass = 0;

   sdram_burst_timing #(.CSLT_W(2), .BRST_W(3)) dut (
      .Clk(Clk), .Reset(Reset),
      .cslt_max(cslt_max), .ld_cslt(ld_cslt), .cslt_end(cslt_end),
      .brst_max(brst_max), .ld_brst(ld_brst), .brst_end(brst_end),
      .brst_end_m1(brst_end_m1),
      .dly_a(dly_a), .dly_d(dly_d), .dly_q(dly_q)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic       ld_c;
      logic [1:0] cm;
      logic       ld_b;
      logic [2:0] bm;
      logic       d;
      logic [3:0] a;
      logic       ce;
      logic       be;
      logic       m1;
      logic       q;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string name, input logic act, input logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
   endtask

   task automatic chk4(input string name, input logic ce, input logic be,
                       input logic m1, input logic q);
      chk({name, ".cslt_end"}, cslt_end, ce);
      chk({name, ".brst_end"}, brst_end, be);
      chk({name, ".brst_end_m1"}, brst_end_m1, m1);
      chk({name, ".dly_q"}, dly_q, q);
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      ld_cslt = 1'b0; cslt_max = 2'd0;
      ld_brst = 1'b0; brst_max = 3'd0;
      dly_d = 1'b0; dly_a = 4'd0;
      #1;
      chk4("reset_hold", 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      Reset = 1'b1;
      #1;
      chk4("reset_release", 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   // Reference model: counters expressed as "latched max minus cycles since load"
   int   cas_lat, cas_el, br_lat, br_el;
   logic hist [$];

   task automatic model_reset();
      cas_lat = 0; cas_el = 0; br_lat = 0; br_el = 0;
      hist.delete();
      for (int i = 0; i < 16; i++) hist.push_back(1'b0);
   endtask

   task automatic model_edge(input logic lc, input int cm, input logic lb,
                             input int bm, input logic d);
      if (lc) begin cas_lat = cm; cas_el = 0; end
      else if (cas_el < 1000) cas_el++;
      if (lb) begin br_lat = bm; br_el = 0; end
      else if (br_el < 1000) br_el++;
      hist.push_front(d);
      void'(hist.pop_back());
   endtask

   function automatic int remain(input int lat, input int el);
      return (lat > el) ? lat - el : 0;
   endfunction

   initial begin
      tbl[0]  = '{1'b1, 2'd2, 1'b1, 3'd4, 1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 2'd2, 1'b0, 3'd4, 1'b0, 4'd4,  1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 4'd4,  1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 4'd4,  1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 4'd4,  1'b1, 1'b1, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 4'd4,  1'b1, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 4'd6,  1'b1, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 2'd0, 1'b1, 3'd1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 2'd3, 1'b0, 3'd0, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 2'd0, 1'b0, 3'd0, 1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 2'd0, 1'b0, 3'd0, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 2'd0, 1'b1, 3'd3, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 2'd0, 1'b1, 3'd3, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 2'd0, 1'b1, 3'd1, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[17] = '{1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0};

      do_reset();

      // Directed table
      for (int i = 0; i < 18; i++) begin
         ld_cslt = tbl[i].ld_c; cslt_max = tbl[i].cm;
         ld_brst = tbl[i].ld_b; brst_max = tbl[i].bm;
         dly_d = tbl[i].d; dly_a = tbl[i].a;
         step();
         chk4($sformatf("vec%0d", i), tbl[i].ce, tbl[i].be, tbl[i].m1, tbl[i].q);
      end

      // Burst reload at count 2 restarts from max
      ld_cslt = 1'b0; dly_d = 1'b0;
      brst_max = 3'd5; ld_brst = 1'b1;
      step();
      ld_brst = 1'b0;
      step(); step(); step();
      chk("reload_pre.brst_end", brst_end, 1'b0);
      chk("reload_pre.brst_end_m1", brst_end_m1, 1'b0);
      ld_brst = 1'b1;
      step();
      ld_brst = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk($sformatf("reload_e%0d.brst_end", i), brst_end, (i == 5));
         chk($sformatf("reload_e%0d.brst_end_m1", i), brst_end_m1, (i == 4));
      end

      // Shift in 1011 (with counters loaded on the last edge), sweep taps unclocked
      dly_d = 1'b1; step();
      dly_d = 1'b0; step();
      dly_d = 1'b1; step();
      dly_d = 1'b1; ld_cslt = 1'b1; cslt_max = 2'd3; ld_brst = 1'b1; brst_max = 3'd6;
      step();
      ld_cslt = 1'b0; ld_brst = 1'b0; dly_d = 1'b0;
      begin
         logic [3:0] pat;
         pat = 4'b1011;
         for (int a = 0; a < 4; a++) begin
            dly_a = 4'(a);
            #1;
            chk($sformatf("pattern_tap%0d", a), dly_q, pat[a]);
         end
      end
      chk("preasync.cslt_end", cslt_end, 1'b0);
      chk("preasync.brst_end", brst_end, 1'b0);

      // Asynchronous reset mid-cycle: outputs clear without a clock edge
      Reset = 1'b0;
      #1;
      chk("async.cslt_end", cslt_end, 1'b1);
      chk("async.brst_end", brst_end, 1'b1);
      chk("async.brst_end_m1", brst_end_m1, 1'b0);
      for (int a = 0; a < 16; a++) begin
         dly_a = 4'(a);
         #0.2;
         chk($sformatf("async_tap%0d", a), dly_q, 1'b0);
      end

      // Randomized run against the reference model
      do_reset();
      model_reset();
      for (int n = 0; n < 600; n++) begin
         logic lc, lb, d;
         int   cm, bm;
         lc = ($urandom_range(0, 6) == 0);
         lb = ($urandom_range(0, 9) == 0);
         cm = $urandom_range(0, 3);
         bm = $urandom_range(0, 7);
         d  = $urandom_range(0, 1);
         ld_cslt = lc; cslt_max = 2'(cm);
         ld_brst = lb; brst_max = 3'(bm);
         dly_d = d; dly_a = 4'($urandom_range(0, 15));
         step();
         model_edge(lc, cm, lb, bm, d);
         chk4($sformatf("rand%0d", n),
              remain(cas_lat, cas_el) == 0,
              remain(br_lat, br_el) == 0,
              remain(br_lat, br_el) == 1,
              hist[dly_a]);
         if (n % 7 == 0) begin
            dly_a = 4'($urandom_range(0, 15));
            #1;
            chk($sformatf("rand%0d_retap", n), dly_q, hist[dly_a]);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
